// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter fed by a 4-entry byte FIFO
// Frames chain back-to-back while the FIFO holds data; overflow is sticky until reset.
module uart_tx_fifo #(
  parameter int BIT_NUM      = 8,
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [BIT_NUM-1:0] wr_data,
  output logic               tx,
  output logic               busy,
  output logic               full,
  output logic               empty,
  output logic [2:0]         count,
  output logic               overflow
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (BIT_NUM > 1) ? $clog2(BIT_NUM) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_NUM - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  state_t             state_next;
  logic [BIT_NUM-1:0] mem [4];
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_ptr;
  logic [CW-1:0]      baud_cnt;
  logic [BW-1:0]      bit_idx;
  logic [BIT_NUM-1:0] shift;
  logic [BIT_NUM-1:0] shift_nx;
  logic               wr_ok;
  logic               pop;
  logic               baud_done;

  assign full      = (count == 3'd4);
  assign empty     = (count == 3'd0);
  assign busy      = (state != IDLE);
  assign wr_ok     = wr_en && !full;
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign shift_nx  = shift >> 1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) state_next = DATA;
      end
      DATA: begin
        if (baud_done && bit_idx == BIT_LAST) state_next = STOP;
      end
      STOP: begin
        // Chain straight into the next start bit so queued bytes leave no idle gap.
        if (baud_done) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, wr_ok} - {2'b00, pop};
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            tx    <= 1'b0;
          end else begin
            tx <= 1'b1;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + BW'(1);
              shift   <= shift_nx;
              tx      <= shift_nx[0];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
            end else begin
              tx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter BIT_NUM, default 8, data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 10416, clk cycles per bit (100 MHz / 9600 baud).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  write strobe, one byte per asserted cycle.
REQ-006 SHALL have port wr_data  input  BIT_NUM  byte to enqueue.
REQ-007 SHALL have port tx  output  1  serial line to the receiver, idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is on the line.
REQ-009 SHALL have port full  output  1  FIFO holds 4 entries.
REQ-010 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-011 SHALL have port count  output  3  FIFO occupancy, 0..4.
REQ-012 SHALL have port overflow  output  1  sticky flag, write dropped while full.

Function
REQ-013 FIFO SHALL be 4 entries deep, circular, with 2-bit read/write pointers that wrap 3->0.
REQ-014 wr_en with full=0 SHALL store wr_data at the write pointer and increment count on the same edge.
REQ-015 wr_en with full=1 SHALL drop the byte, leave FIFO unchanged, and set overflow=1 until reset, even if a pop occurs on the same edge.
REQ-016 A simultaneous accepted write and pop SHALL leave count unchanged.
REQ-017 Frame format SHALL be 1 start bit (0), BIT_NUM data bits LSB first, 1 stop bit (1), with no parity.
REQ-018 Each bit SHALL hold tx for exactly CLKS_PER_BIT clk cycles, timed by an internal counter in the clk domain with no derived clock.
REQ-019 FSM states SHALL be IDLE, START, DATA, and STOP.
REQ-020 IDLE with empty=0 SHALL pop the head into the shift register, go to START, and drive tx=0 from that edge (latency 1 cycle from the first accepted write into an empty idle FIFO).
REQ-021 START SHALL go to DATA after CLKS_PER_BIT cycles.
REQ-022 DATA SHALL shift out bit index 0..BIT_NUM-1 and go to STOP after the last bit's CLKS_PER_BIT cycles.
REQ-023 At the end of STOP, the FSM SHALL pop and go to START directly if empty=0 (no idle gap between frames), else go to IDLE.
REQ-024 tx SHALL be a registered output with no combinational glitches.
REQ-025 busy SHALL be 1 in START, DATA, and STOP, and 0 in IDLE.
REQ-026 full SHALL equal (count==4), and empty SHALL equal (count==0).
REQ-027 A popped byte SHALL be transmitted completely; FIFO writes during a frame SHALL NOT alter the frame in flight.

Reset
REQ-028 reset=0 SHALL immediately set: state IDLE, tx=1, busy=0, count=0, empty=1, full=0, overflow=0, pointers=0, bit and baud counters=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame, drive tx=1 at once, and discard all FIFO contents.
REQ-030 After reset deassertion, tx SHALL stay 1 until the first accepted write.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-031 Bench SHALL cover: single write 0xA5 while idle -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy=1 for 40 cycles; then tx=1, busy=0, empty=1.
REQ-032 Bench SHALL cover: writes 0x01..0x06 on 6 consecutive cycles from idle -> 0x01 popped on the second edge; 0x02..0x05 fill the FIFO (full=1, count=4); 0x06 dropped, overflow=1; five back-to-back frames with no idle cycle between stop and next start.
REQ-033 Bench SHALL cover: write while count=3 with a STOP-end pop on the same edge -> write accepted, count stays 3, overflow=0.
REQ-034 Bench SHALL cover: reset=0 during the 4th data bit of frame 0x3C with 2 bytes queued -> tx=1 and count=0 without waiting for a clk edge; no further frames after release.
REQ-035 Bench SHALL cover loopback: tx into the team's receiver at default parameters (CLKS_PER_BIT=10416), bytes 0x55, 0x00, 0xFF -> receiver outputs the same bytes in order with isSuccessful pulses.
